fetch_controller: RTL and testbench

//  Sequences the instruction-fetch stage: owns the program counter and drives
//  the request/ready handshake to a multi-cycle instruction memory. Applies

---
 rtl/if_pkg.sv | 17 +
 rtl/fetch_pc_reg.sv | 39 +++
 rtl/fetch_controller.sv | 146 ++++++++++++++
 tb/tb_fetch_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage blocks and their bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

    localparam int          IF_DATA_W   = 16;
    localparam int          IF_PC_INC   = 4;
    localparam logic [15:0] IF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: load on redirect, increment on capture, else hold.
// Latency: new value visible one cycle after load/inc; pc_next is same-cycle.
// Backpressure: none; the controller simply withholds load/inc to stall.
module fetch_pc_reg
    import if_pkg::*;
#(
    parameter int                 DATA_W   = IF_DATA_W,
    parameter int                 PC_INC   = IF_PC_INC,
    parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(IF_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              inc,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_next
);

    // Redirect beats increment; the add wraps modulo 2^DATA_W with no carry out.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_val;
        end else if (inc) begin
            pc_next = pc + DATA_W'(PC_INC);
        end
    end

    // PC state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the fetch PC, handshakes with imem, registers one instruction for IF/ID.
// Latency: 1 cycle from request with imem_ready to instr_valid; one BOOT cycle after reset.
// Backpressure: stall parks in HOLD after the outstanding request lands; redirects squash in-flight words.
module fetch_controller
    import if_pkg::*;
#(
    parameter int                 DATA_W   = IF_DATA_W,
    parameter int                 PC_INC   = IF_PC_INC,
    parameter logic [DATA_W-1:0]  RESET_PC = DATA_W'(IF_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_plus,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid
);

    fetch_state_t      state_q, state_d;
    logic              squash_q, squash_d;
    logic              valid_d;
    logic              req_d;
    logic [DATA_W-1:0] addr_d;
    logic              capture;
    logic              pc_load;
    logic              pc_inc;
    logic [DATA_W-1:0] fetch_pc;
    logic [DATA_W-1:0] fetch_pc_next;

    fetch_pc_reg #(
        .DATA_W   (DATA_W),
        .PC_INC   (PC_INC),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (pc_load),
        .load_val (branch_target),
        .inc      (pc_inc),
        .pc       (fetch_pc),
        .pc_next  (fetch_pc_next)
    );

    // Next-state, PC control and next register values; redirect outranks capture and stall.
    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        valid_d  = instr_valid;
        capture  = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        case (state_q)
            BOOT: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                end
                valid_d = 1'b0;
                state_d = FETCH;
            end
            FETCH, WAIT: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        // Word arriving now belongs to the old path: drop it and go straight to the target.
                        squash_d = 1'b0;
                        state_d  = FETCH;
                    end else begin
                        // Request stays outstanding; remember to discard whatever it returns.
                        squash_d = 1'b1;
                        state_d  = WAIT;
                    end
                end else if (imem_ready) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        valid_d  = 1'b0;
                    end else begin
                        capture = 1'b1;
                        pc_inc  = 1'b1;
                        valid_d = 1'b1;
                    end
                    state_d = stall ? HOLD : FETCH;
                end else begin
                    valid_d = 1'b0;
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    state_d = FETCH;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = BOOT;
            end
        endcase
        req_d  = (state_d == FETCH) || (state_d == WAIT);
        // A new request takes the next fetch PC; an outstanding one keeps its address.
        addr_d = (state_d == FETCH) ? fetch_pc_next : imem_addr;
    end

    // FSM state, squash flag and the request/address outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            squash_q  <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state_q   <= state_d;
            squash_q  <= squash_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
        end
    end

    // IF/ID capture registers; only a non-squashed returning word updates them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_out   <= '0;
            pc_out      <= '0;
            pc_plus     <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= valid_d;
            if (capture) begin
                instr_out <= imem_rdata;
                pc_out    <= fetch_pc;
                pc_plus   <= fetch_pc_next;
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
    import if_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc_out;
    logic [15:0] pc_plus;
    logic [15:0] instr_out;
    logic        instr_valid;

    int errors = 0;
    int checks = 0;

    fetch_controller #(
        .DATA_W   (16),
        .PC_INC   (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid)
    );

    // Memory returns the inverted address as the instruction word.
    assign imem_rdata = ~imem_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_ready    = 1'b1;
        step();
        step();

        // Reset state
        chkb("rst_req",   imem_req,    1'b0);
        chkb("rst_valid", instr_valid, 1'b0);
        chk ("rst_instr", instr_out,   16'h0000);
        chk ("rst_pc",    pc_out,      16'h0000);
        chk ("rst_pcplus",pc_plus,     16'h0000);

        // 1: ready tied high, sequential fetch
        reset_n = 1'b1;
        step();                                 // BOOT -> FETCH
        chkb("t1_req1",   imem_req,    1'b1);
        chk ("t1_addr1",  imem_addr,   16'h0000);
        chkb("t1_valid1", instr_valid, 1'b0);
        step();                                 // capture 0000
        chk ("t1_addr2",  imem_addr,   16'h0004);
        chkb("t1_valid2", instr_valid, 1'b1);
        chk ("t1_pc2",    pc_out,      16'h0000);
        chk ("t1_instr2", instr_out,   16'hFFFF);
        chk ("t1_pcplus2",pc_plus,     16'h0004);
        step();                                 // capture 0004
        chk ("t1_addr3",  imem_addr,   16'h0008);
        chk ("t1_pc3",    pc_out,      16'h0004);
        chk ("t1_instr3", instr_out,   16'hFFFB);

        // 2: ready withheld for 3 cycles on the request to 0008
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chkb("t2_req",   imem_req,    1'b1);
            chk ("t2_addr",  imem_addr,   16'h0008);
            chkb("t2_valid", instr_valid, 1'b0);
            chk ("t2_pc",    pc_out,      16'h0004);
        end
        imem_ready = 1'b1;
        step();                                 // single capture of 0008
        chkb("t2_valid_cap", instr_valid, 1'b1);
        chk ("t2_pc_cap",    pc_out,      16'h0008);
        chk ("t2_instr_cap", instr_out,   16'hFFF7);
        chk ("t2_pcplus",    pc_plus,     16'h000C);
        chk ("t2_addr_next", imem_addr,   16'h000C);

        // 3: stall for 5 cycles; 000C is still captured, then HOLD
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chkb("t3_req",   imem_req,    1'b0);
            chkb("t3_valid", instr_valid, 1'b1);
            chk ("t3_pc",    pc_out,      16'h000C);
            chk ("t3_instr", instr_out,   16'hFFF3);
        end
        stall = 1'b0;
        step();                                 // HOLD -> FETCH
        chkb("t3_req_resume",  imem_req,  1'b1);
        chk ("t3_addr_resume", imem_addr, 16'h0010);
        step();                                 // capture 0010
        chk ("t3_pc_resume",   pc_out,      16'h0010);
        chkb("t3_valid_resume",instr_valid, 1'b1);

        // 4: redirect to 0040 while waiting on 0014
        imem_ready = 1'b0;
        step();                                 // WAIT on 0014
        chk ("t4_addr_wait", imem_addr, 16'h0014);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        step();                                 // squash armed, request still held
        chkb("t4_req_held",  imem_req,    1'b1);
        chk ("t4_addr_held", imem_addr,   16'h0014);
        chkb("t4_valid_sq",  instr_valid, 1'b0);
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        step();                                 // returning word dropped
        chkb("t4_valid_drop", instr_valid, 1'b0);
        chk ("t4_instr_keep", instr_out,   16'hFFEF);
        chk ("t4_addr_tgt",   imem_addr,   16'h0040);
        step();                                 // capture 0040
        chk ("t4_addr_next",  imem_addr,   16'h0044);
        chk ("t4_pc_tgt",     pc_out,      16'h0040);
        chk ("t4_instr_tgt",  instr_out,   16'hFFBF);

        // 5: branch, stall and ready together; redirect wins
        branch_taken  = 1'b1;
        branch_target = 16'h0080;
        stall         = 1'b1;
        step();
        chkb("t5_valid", instr_valid, 1'b0);
        chkb("t5_req",   imem_req,    1'b1);
        chk ("t5_addr",  imem_addr,   16'h0080);
        chk ("t5_pc",    pc_out,      16'h0040);
        branch_taken = 1'b0;
        stall        = 1'b0;
        step();
        chk ("t5_pc_cap",  pc_out,  16'h0080);
        chk ("t5_pcplus",  pc_plus, 16'h0084);

        // 6: wrap from FFFC, then reset in the middle of a WAIT
        branch_taken  = 1'b1;
        branch_target = 16'hFFFC;
        step();
        chk ("t6_addr_fffc", imem_addr, 16'hFFFC);
        branch_taken = 1'b0;
        step();                                 // capture FFFC
        chk ("t6_pc",       pc_out,    16'hFFFC);
        chk ("t6_instr",    instr_out, 16'h0003);
        chk ("t6_pcplus",   pc_plus,   16'h0000);
        chk ("t6_addr_wrap",imem_addr, 16'h0000);
        imem_ready = 1'b0;
        step();                                 // WAIT on 0000
        chkb("t6_req_wait", imem_req, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        chkb("t6_req_async",   imem_req,    1'b0);
        chkb("t6_valid_async", instr_valid, 1'b0);
        imem_ready = 1'b1;                      // late ready while in reset/BOOT
        step();
        reset_n = 1'b1;
        step();                                 // BOOT -> FETCH, ready ignored
        chkb("t6_valid_boot", instr_valid, 1'b0);
        chk ("t6_pc_boot",    pc_out,      16'h0000);
        chkb("t6_req_boot",   imem_req,    1'b1);
        chk ("t6_addr_boot",  imem_addr,   16'h0000);
        step();
        chkb("t6_valid_restart", instr_valid, 1'b1);
        chk ("t6_instr_restart", instr_out,   16'hFFFF);
        chk ("t6_addr_restart",  imem_addr,   16'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
